memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  Pipeline MEM stage directly downstream of the execute stage.
//  - Registers the EX result (ALU result, store data, load/store controls).
//  - Performs loads and stores over a req/ack data-memory handshake with a timeout.
//  - Aligns and sign-extends load data; drives write-back and the MEM->EX forwarding value.
//  - Stalls upstream while a memory transaction is outstanding.
// PARAMETERS
//  ADDR_W       32  width of dmem_addr; low ADDR_W bits of ex_alu_data
//  ACK_TIMEOUT  16  max cycles dmem_req is held before bus_error; legal range 1..255
// PORTS
//  clk              in   1       single clock, rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  ex_valid         in   1       EX presents an instruction this cycle
//  ex_ready         out  1       stage can accept; transfer = ex_valid & ex_ready
//  ex_alu_data      in   32      ALU result: effective address or write-back value
//  ex_store_data    in   32      rs2 value for stores
//  ex_mem_read      in   1       load
//  ex_mem_write     in   1       store; ex_mem_read and ex_mem_write both 1 is illegal, treated as load
//  ex_funct3        in   3       000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; SB/SH/SW use 000/001/010
//  ex_rd            in   5       destination register
//  ex_reg_write     in   1       instruction writes rd
//  dmem_req         out  1       request, held until dmem_ack or timeout
//  dmem_we          out  1       1 = write
//  dmem_addr        out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}
//  dmem_wdata       out  32      store data replicated into byte lanes
//  dmem_be          out  4       byte enables
//  dmem_rdata       in   32      read data, valid in the cycle dmem_ack=1
//  dmem_ack         in   1       completes the request; ignored when dmem_req=0
//  wb_valid         out  1       one-cycle pulse: result to write-back
//  wb_rd            out  5       destination register
//  wb_reg_write     out  1       write enable (forced 0 on bus_error)
//  wb_data          out  32      load result or passed-through ALU result
//  mem_forward_data out  32      registered ALU result of the held instruction (forward_a/b = 2'b10)
//  bus_error        out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; ex_ready=0 while reset_n=0; counter cleared.
//    Reset mid-transaction aborts it immediately; no wb_valid is produced.
//  - FSM IDLE -> ACCESS -> IDLE. ex_ready = (state==IDLE).
//  - IDLE, transfer, no memory op:
//    - Capture inputs.
//    - Next cycle: wb_valid=1, wb_data=ALU result. Latency 1. Stay IDLE.
//  - IDLE, transfer, load/store:
//    - Capture inputs; go to ACCESS.
//    - dmem_req=1 from the next cycle; dmem_we/addr/wdata/be are stable while req=1.
//  - ACCESS:
//    - Counter increments each cycle.
//    - dmem_ack=1: register result; next cycle wb_valid=1, state IDLE.
//      Back-to-back instructions are accepted in that same cycle.
//    - Counter reaches ACK_TIMEOUT with no ack: drop req; next cycle bus_error=1,
//      wb_valid=1, wb_reg_write=0, state IDLE.
//    - ack and timeout in the same cycle: ack wins.
//  - Byte lanes, off = addr[1:0]:
//    - SB: be = 1<<off.
//    - SH: be = 0011 (off=0) or 1100 (off=2).
//    - SW: be = 1111.
//    - wdata = byte/half replicated.
//  - Loads: select the lane by off.
//    - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: unchanged.
//  - Stores: wb_reg_write=0 regardless of ex_reg_write.
//  - mem_forward_data holds the captured ALU result until the next transfer.
//  - Counter is 8 bits; no wrap (saturates at ACK_TIMEOUT).
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN
//  - Defined:
//    - Misaligned access: LH/LHU/SH with off odd; LW/SW with off!=0.
//    - Issues no dmem_req. Next cycle: bus_error=1, wb_valid=1, wb_reg_write=0.
//  - Undefined:
//    - Misaligned access: addr[0] (halfword) or addr[1:0] (word) is ignored, i.e.
//      the address is truncated to the natural boundary.
//    - Access proceeds normally; bus_error only on timeout.
// TESTING
//  - ALU op (rd=5, data 0x1234) -> wb_valid 1 cycle later, wb_data=0x1234, no dmem_req.
//  - LB @0x103, rdata 0x80FF_FF00, ack after 3 cycles
//    -> be=1000, wb_data=0xFFFF_FF80 one cycle after ack; ex_ready low throughout.
//  - SH @0x102, data 0xABCD -> be=1100, wdata=0xABCD_ABCD, we=1, wb_reg_write=0.
//  - No ack, ACK_TIMEOUT=16 -> req drops after 16 cycles; bus_error and wb_valid
//    pulse once; ex_ready returns.
//  - reset_n low during ACCESS -> req=0 immediately, no wb_valid; fresh load after
//    release completes normally.
//  - LW @0x102 -> with MEM_MISALIGN_TRAP_EN: bus_error, no req;
//    without: addr=0x100, be=1111.

Source files
------------

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// Pipeline MEM stage sitting after EX. It registers the EX result and performs
// loads and stores over a req/ack data-memory handshake with an ack timeout.
// It aligns and extends load data, drives write-back and the forwarding value,
// and holds off upstream (ex_ready=0) while a memory transaction is open.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW issue no request and raise bus_error
//   undefined : misaligned addresses are truncated to the natural boundary
//
// Parameters
//   ADDR_W      width of dmem_addr (low ADDR_W bits of ex_alu_data), <= 32
//   ACK_TIMEOUT cycles dmem_req is held before bus_error, 1..255
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   ex_valid/ex_ready                 EX handshake (transfer = valid & ready)
//   ex_alu_data, ex_store_data        ALU result / store data
//   ex_mem_read, ex_mem_write         load / store (both set -> load)
//   ex_funct3, ex_rd, ex_reg_write    access size, destination, rd write enable
//   dmem_req/we/addr/wdata/be         data-memory request (held until ack/timeout)
//   dmem_rdata, dmem_ack              data-memory response
//   wb_valid/rd/reg_write/data        write-back result (wb_valid is a pulse)
//   mem_forward_data                  ALU result of the held instruction
//   bus_error                         one-cycle pulse on timeout / trap
// -----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_alu_data,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic [31:0]       mem_forward_data,
  output logic              bus_error
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_alu;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;

  logic        w_transfer;
  logic        w_mem_op;
  logic        w_is_store;
  logic        w_trap;
  logic        w_timeout;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // FSM control strobes
  logic w_capture, w_start, w_direct, w_trap_done, w_ack_done, w_to_done, w_count;

  assign ex_ready         = (r_state == ST_IDLE) && reset_n;
  assign w_transfer       = ex_valid && ex_ready;
  assign w_mem_op         = ex_mem_read || ex_mem_write;
  assign w_is_store       = ex_mem_write && !ex_mem_read;  // read+write acts as load
  assign w_off            = ex_alu_data[1:0];
  assign w_timeout        = (r_cnt == CNT_LAST);
  assign mem_forward_data = r_alu;

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = (w_off != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  // Store lane steering; halfword uses off[1] only, word ignores off
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << w_off);
        w_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half      = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; ack takes priority over timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_transfer && w_mem_op && !w_trap) w_state_next = ST_ACCESS;
      ST_ACCESS: if (dmem_ack || w_timeout)             w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Control strobes per state
  always_comb begin
    w_capture   = 1'b0;
    w_start     = 1'b0;
    w_direct    = 1'b0;
    w_trap_done = 1'b0;
    w_ack_done  = 1'b0;
    w_to_done   = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_transfer) begin
          w_capture = 1'b1;
          if (!w_mem_op)   w_direct    = 1'b1;
          else if (w_trap) w_trap_done = 1'b1;
          else             w_start     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack)       w_ack_done = 1'b1;
        else if (w_timeout) w_to_done  = 1'b1;
        else                w_count    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_alu        <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      bus_error    <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      bus_error <= 1'b0;
      if (w_capture) begin
        r_alu       <= ex_alu_data;
        r_rd        <= ex_rd;
        r_reg_write <= ex_reg_write;
        r_is_store  <= w_is_store;
        r_funct3    <= ex_funct3;
        r_off       <= w_off;
      end
      if (w_start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= w_is_store;
        dmem_addr  <= {ex_alu_data[ADDR_W-1:2], 2'b00};
        dmem_wdata <= w_wdata;
        dmem_be    <= w_be;
        r_cnt      <= '0;
      end
      if (w_direct) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_reg_write <= ex_reg_write;
        wb_data      <= ex_alu_data;
      end
      if (w_trap_done) begin
        wb_valid     <= 1'b1;
        bus_error    <= 1'b1;
        wb_rd        <= ex_rd;
        wb_reg_write <= 1'b0;
        wb_data      <= '0;
      end
      if (w_ack_done) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= r_rd;
        wb_reg_write <= r_reg_write && !r_is_store;
        wb_data      <= r_is_store ? r_alu : w_load_data;
      end
      if (w_to_done) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        bus_error    <= 1'b1;
        wb_rd        <= r_rd;
        wb_reg_write <= 1'b0;
        wb_data      <= '0;
      end
      if (w_count && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage.
module tb_memory_access_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_data;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [31:0] mem_forward_data;
  logic        bus_error;

  memory_access_stage #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .mem_forward_data(mem_forward_data),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic        rw;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    logic        e_rw;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[12];

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sd,
                              input logic mr, input logic mw, input logic [2:0] f3,
                              input logic rw, input logic [31:0] rdata, input int dly,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic e_we, input logic [31:0] e_wdata,
                              input logic [31:0] e_wb, input logic e_rw);
    vec_t v;
    v.alu = alu; v.sd = sd; v.mr = mr; v.mw = mw; v.f3 = f3; v.rw = rw;
    v.rdata = rdata; v.dly = dly; v.e_addr = e_addr; v.e_be = e_be;
    v.e_we = e_we; v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_rw = e_rw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_alu_data   = v.alu;
    ex_store_data = v.sd;
    ex_mem_read   = v.mr;
    ex_mem_write  = v.mw;
    ex_funct3     = v.f3;
    ex_rd         = rd;
    ex_reg_write  = v.rw;
  endtask

  task automatic do_vec(input vec_t v, input logic [4:0] rd);
    @(negedge clk);
    chk("ready_before", ex_ready, 1);
    chk("wb_valid_idle", wb_valid, 0);
    issue(v, rd);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("fwd_data", mem_forward_data, v.alu);
    if (!(v.mr || v.mw)) begin
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_data", wb_data, v.e_wb);
      chk("alu_wb_rd", wb_rd, rd);
      chk("alu_wb_rw", wb_reg_write, v.e_rw);
      chk("alu_no_req", dmem_req, 0);
    end else begin
      chk("mem_req", dmem_req, 1);
      chk("mem_we", dmem_we, v.e_we);
      chk("mem_addr", dmem_addr, v.e_addr);
      chk("mem_be", dmem_be, v.e_be);
      if (v.e_we) chk("mem_wdata", dmem_wdata, v.e_wdata);
      chk("mem_ready_low", ex_ready, 0);
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clk);
        chk("wait_req", dmem_req, 1);
        chk("wait_ready_low", ex_ready, 0);
        chk("wait_no_wb", wb_valid, 0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      chk("ack_wb_valid", wb_valid, 1);
      chk("ack_wb_data", wb_data, v.e_wb);
      chk("ack_wb_rd", wb_rd, rd);
      chk("ack_wb_rw", wb_reg_write, v.e_rw);
      chk("ack_req_drop", dmem_req, 0);
      chk("ack_no_err", bus_error, 0);
      chk("ack_ready", ex_ready, 1);
    end
  endtask

  initial begin
    int n;
    vec_t v;
    //          alu           sd            mr mw f3     rw rdata         dly addr          be       we wdata         wb            rw
    vecs[0]  = mk(32'h1234,     32'h0,        0, 0, 3'b000, 1, 32'h0,        0, 32'h0,       4'b0000, 0, 32'h0,        32'h1234,     1);
    vecs[1]  = mk(32'h103,      32'h0,        1, 0, 3'b000, 1, 32'h80FFFF00, 3, 32'h100,     4'b1000, 0, 32'h0,        32'hFFFFFF80, 1);
    vecs[2]  = mk(32'h102,      32'h1234ABCD, 0, 1, 3'b001, 1, 32'h0,        2, 32'h100,     4'b1100, 1, 32'hABCDABCD, 32'h102,      0);
    vecs[3]  = mk(32'h201,      32'h0,        1, 0, 3'b100, 1, 32'h12348056, 0, 32'h200,     4'b0010, 0, 32'h0,        32'h00000080, 1);
    vecs[4]  = mk(32'h202,      32'h0,        1, 0, 3'b001, 1, 32'h80017FFF, 1, 32'h200,     4'b1100, 0, 32'h0,        32'hFFFF8001, 1);
    vecs[5]  = mk(32'h200,      32'h0,        1, 0, 3'b101, 1, 32'h12349ABC, 0, 32'h200,     4'b0011, 0, 32'h0,        32'h00009ABC, 1);
    vecs[6]  = mk(32'h304,      32'h0,        1, 0, 3'b010, 1, 32'hDEADBEEF, 2, 32'h304,     4'b1111, 0, 32'h0,        32'hDEADBEEF, 1);
    vecs[7]  = mk(32'h3,        32'hFFFFFF5A, 0, 1, 3'b000, 0, 32'h0,        0, 32'h0,       4'b1000, 1, 32'h5A5A5A5A, 32'h3,        0);
    vecs[8]  = mk(32'h10,       32'hCAFEF00D, 0, 1, 3'b010, 1, 32'h0,        1, 32'h10,      4'b1111, 1, 32'hCAFEF00D, 32'h10,       0);
    vecs[9]  = mk(32'hFFFF0000, 32'h0,        0, 0, 3'b000, 0, 32'h0,        0, 32'h0,       4'b0000, 0, 32'h0,        32'hFFFF0000, 0);
    vecs[10] = mk(32'h40,       32'h55555555, 1, 1, 3'b010, 1, 32'h11223344, 0, 32'h40,      4'b1111, 0, 32'h0,        32'h11223344, 1);
    vecs[11] = mk(32'h102,      32'h0,        1, 0, 3'b000, 1, 32'h00A50000, 1, 32'h100,     4'b0100, 0, 32'h0,        32'hFFFFFFA5, 1);

    reset_n = 1'b0; ex_valid = 1'b0; ex_alu_data = '0; ex_store_data = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ex_ready, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_fwd", mem_forward_data, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) do_vec(vecs[i], 5'(i + 1));

    // Back-to-back: new instruction accepted in the write-back cycle
    @(negedge clk);
    issue(mk(32'h20, 0, 1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'd4);
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("b2b_ld_wb", wb_data, 32'hA5A50001);
    chk("b2b_ready", ex_ready, 1);
    issue(mk(32'h77, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'd9);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_alu_valid", wb_valid, 1);
    chk("b2b_alu_data", wb_data, 32'h77);
    chk("b2b_alu_rd", wb_rd, 9);

    // Timeout: no ack
    @(negedge clk);
    issue(mk(32'h500, 0, 1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'd3);
    @(negedge clk);
    ex_valid = 1'b0;
    n = 0;
    while (dmem_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, TO);
    chk("to_bus_error", bus_error, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_reg_write, 0);
    chk("to_ready", ex_ready, 1);
    @(negedge clk);
    chk("to_err_pulse", bus_error, 0);
    chk("to_wbv_pulse", wb_valid, 0);

    // Reset during ACCESS
    issue(mk(32'h80, 0, 1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'd6);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rma_req", dmem_req, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rma_req_drop", dmem_req, 0);
    chk("rma_ready", ex_ready, 0);
    chk("rma_wbv", wb_valid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rma_hold_wbv", wb_valid, 0);
    end
    reset_n = 1'b1;
    do_vec(vecs[6], 5'd7);

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    issue(mk(32'h102, 0, 1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'd8);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mis_no_req", dmem_req, 0);
    chk("mis_bus_error", bus_error, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_rw", wb_reg_write, 0);
    @(negedge clk);
    chk("mis_err_pulse", bus_error, 0);
`else
    v = mk(32'h102, 0, 1, 0, 3'b010, 1, 32'h0BADF00D, 0, 32'h100, 4'b1111, 0, 0, 32'h0BADF00D, 1);
    do_vec(v, 5'd8);
    @(negedge clk);
    chk("mis_no_err", bus_error, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
